pipeline_hazard_ctrl: RTL and testbench

//  Per-core pipeline sequencer. Drives en/flush of IF_ID, ID_EX, EX_MEM and MEM_WB latches plus pc_en.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 16 +
 rtl/pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type, hazard sequencer states and
// the bundle of latch controls the hazard sequencer produces each cycle.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MEMWAIT,
        HZ_DRAIN,
        HZ_HALTED
    } hzstate_t;

    // Drain counter must hold DRAIN_CYCLES-1 for the largest legal value (15)
    localparam int DRAIN_CNT_W = 4;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } hzctl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the EX-stage load writes a register that the
// ID-stage instruction reads. Register 0 never creates a dependency.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_dREN,
    input  regbits_t idex_rd,
    input  regbits_t ifid_rs1,
    input  regbits_t ifid_rs2,
    output logic     lu
);

    assign lu = idex_dREN && (idex_rd != '0) &&
                ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-core pipeline sequencer: stalls, flushes and bubbles the four pipeline
// latches and the PC, and drains then freezes the core after a halt.
// Optional feature macro HAZ_PERF_EN adds stall_cnt/flush_cnt perf counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        exmem_redirect,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        memwb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        memwb_flush,
    output logic        halt_o
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    hzstate_t               state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    hzctl_t                 ctl;
    logic                   lu;
    logic                   mstall;
    logic                   active;

    load_use_detect u_lu (
        .idex_dREN (idex_dREN),
        .idex_rd   (idex_rd),
        .ifid_rs1  (ifid_rs1),
        .ifid_rs2  (ifid_rs2),
        .lu        (lu)
    );

    assign mstall = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign active = (state_q == HZ_RUN) || (state_q == HZ_MEMWAIT);

    // State and drain counter registers; reset always lands back in RUN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= HZ_RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state: a halt reaching WB always wins over a pending memory stall
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (memwb_halt) begin
                    state_d     = HZ_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (mstall) begin
                    state_d = HZ_MEMWAIT;
                end
            end
            HZ_MEMWAIT: begin
                if (memwb_halt) begin
                    state_d     = HZ_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (dhit) begin
                    state_d = HZ_RUN;
                end
            end
            HZ_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = HZ_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = HZ_HALTED;
            end
        endcase
    end

    // Latch control priority mux: dcache miss, redirect, load-use, icache miss
    always_comb begin
        ctl = '0;
        case (state_q)
            HZ_RUN, HZ_MEMWAIT: begin
                ctl.pc_en    = 1'b1;
                ctl.ifid_en  = 1'b1;
                ctl.idex_en  = 1'b1;
                ctl.exmem_en = 1'b1;
                ctl.memwb_en = 1'b1;
                if (mstall) begin
                    ctl.pc_en       = 1'b0;
                    ctl.ifid_en     = 1'b0;
                    ctl.idex_en     = 1'b0;
                    ctl.exmem_en    = 1'b0;
                    ctl.memwb_flush = 1'b1;
                end else if (exmem_redirect) begin
                    ctl.ifid_flush  = 1'b1;
                    ctl.idex_flush  = 1'b1;
                    ctl.exmem_flush = 1'b1;
                end else if (lu) begin
                    ctl.pc_en      = 1'b0;
                    ctl.ifid_en    = 1'b0;
                    ctl.idex_flush = 1'b1;
                end else if (!ihit) begin
                    ctl.pc_en      = 1'b0;
                    ctl.ifid_flush = 1'b1;
                end
            end
            HZ_DRAIN: begin
                ctl.ifid_en     = 1'b1;
                ctl.idex_en     = 1'b1;
                ctl.exmem_en    = 1'b1;
                ctl.memwb_en    = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_flush  = 1'b1;
                ctl.exmem_flush = 1'b1;
            end
            default: begin
                ctl = '0;
            end
        endcase
    end

    // A held latch keeps its contents, so a flush only takes effect when enabled
    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign ifid_flush  = ctl.ifid_flush & ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign idex_flush  = ctl.idex_flush & ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign exmem_flush = ctl.exmem_flush & ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign memwb_flush = ctl.memwb_flush & ctl.memwb_en;
    assign halt_o      = (state_q == HZ_HALTED);

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Perf counters advance only while the core runs; they freeze once draining
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (active && !ctl.pc_en) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (active && exmem_redirect) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_active;
    assign unused_active = active;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (DRAIN_CYCLES=2).
// Perf counter checks are built only when HAZ_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect;
    logic       idex_dREN, memwb_halt;
    logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halt_o;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    // Observation order: halt_o, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    // exmem_en, exmem_flush, memwb_en, memwb_flush
    logic [9:0] obs;
    assign obs = {halt_o, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_en, memwb_flush};

    localparam logic [9:0] EXP_NORMAL = 10'b0_1_1_0_1_0_1_0_1_0;
    localparam logic [9:0] EXP_LU     = 10'b0_0_0_0_1_1_1_0_1_0;
    localparam logic [9:0] EXP_MSTALL = 10'b0_0_0_0_0_0_0_0_1_1;
    localparam logic [9:0] EXP_REDIR  = 10'b0_1_1_1_1_1_1_1_1_0;
    localparam logic [9:0] EXP_IMISS  = 10'b0_0_1_1_1_0_1_0_1_0;
    localparam logic [9:0] EXP_DRAIN  = 10'b0_0_1_1_1_1_1_1_1_0;
    localparam logic [9:0] EXP_HALTED = 10'b1_0_0_0_0_0_0_0_0_0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .dhit           (dhit),
        .exmem_dREN     (exmem_dREN),
        .exmem_dWEN     (exmem_dWEN),
        .exmem_redirect (exmem_redirect),
        .idex_dREN      (idex_dREN),
        .idex_rd        (idex_rd),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .memwb_halt     (memwb_halt),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .exmem_flush    (exmem_flush),
        .memwb_en       (memwb_en),
        .memwb_flush    (memwb_flush),
        .halt_o         (halt_o)
`ifdef HAZ_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
        exmem_redirect = 1'b0; idex_dREN = 1'b0; memwb_halt = 1'b0;
        idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #3;
        compared++;
        if (obs !== EXP_NORMAL) begin
            mismatched++;
            $display("[TB] FAIL reset_held: got %b expected %b", obs, EXP_NORMAL);
        end
        nRST = 1'b1;
        tick();
        compared++;
        if (obs !== EXP_NORMAL) begin
            mismatched++;
            $display("[TB] FAIL reset_released: got %b expected %b", obs, EXP_NORMAL);
        end
    endtask

    task automatic test_load_use();
        logic [9:0] exp_tab [5] = '{EXP_LU, EXP_LU, EXP_NORMAL, EXP_NORMAL, EXP_NORMAL};
        logic [4:0] rd_tab  [5] = '{5'd5, 5'd7, 5'd0, 5'd5, 5'd9};
        logic [4:0] rs1_tab [5] = '{5'd1, 5'd7, 5'd0, 5'd3, 5'd1};
        logic [4:0] rs2_tab [5] = '{5'd5, 5'd2, 5'd0, 5'd4, 5'd2};
        logic       ld_tab  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            idex_dREN = ld_tab[i]; idex_rd = rd_tab[i];
            ifid_rs1 = rs1_tab[i]; ifid_rs2 = rs2_tab[i];
            #1;
            compared++;
            if (obs !== exp_tab[i]) begin
                mismatched++;
                $display("[TB] FAIL load_use[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
            tick();
            idle_inputs();
            #1;
            compared++;
            if (obs !== EXP_NORMAL) begin
                mismatched++;
                $display("[TB] FAIL load_use_after[%0d]: got %b expected %b", i, obs, EXP_NORMAL);
            end
        end
        idle_inputs();
        idex_dREN = 1'b0; idex_rd = 5'd5; ifid_rs2 = 5'd5;
        #1;
        compared++;
        if (obs !== EXP_NORMAL) begin
            mismatched++;
            $display("[TB] FAIL load_use_not_load: got %b expected %b", obs, EXP_NORMAL);
        end
        tick();
    endtask

    task automatic test_dcache_miss();
        idle_inputs();
        exmem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (obs !== EXP_MSTALL) begin
                mismatched++;
                $display("[TB] FAIL dmiss_cycle[%0d]: got %b expected %b", i, obs, EXP_MSTALL);
            end
            tick();
        end
        dhit = 1'b1;
        #1;
        compared++;
        if (obs !== EXP_NORMAL) begin
            mismatched++;
            $display("[TB] FAIL dmiss_hit: got %b expected %b", obs, EXP_NORMAL);
        end
        tick();
        idle_inputs();
        exmem_dWEN = 1'b1; exmem_redirect = 1'b1; ihit = 1'b0;
        #1;
        compared++;
        if (obs !== EXP_MSTALL) begin
            mismatched++;
            $display("[TB] FAIL dmiss_store_over_redirect: got %b expected %b", obs, EXP_MSTALL);
        end
        dhit = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_redirect();
        idle_inputs();
        exmem_redirect = 1'b1; idex_dREN = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3;
        #1;
        compared++;
        if (obs !== EXP_REDIR) begin
            mismatched++;
            $display("[TB] FAIL redirect_over_lu: got %b expected %b", obs, EXP_REDIR);
        end
        ihit = 1'b0;
        #1;
        compared++;
        if (obs !== EXP_REDIR) begin
            mismatched++;
            $display("[TB] FAIL redirect_over_imiss: got %b expected %b", obs, EXP_REDIR);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_icache_miss();
        idle_inputs();
        ihit = 1'b0;
        #1;
        compared++;
        if (obs !== EXP_IMISS) begin
            mismatched++;
            $display("[TB] FAIL imiss: got %b expected %b", obs, EXP_IMISS);
        end
        idex_dREN = 1'b1; idex_rd = 5'd8; ifid_rs2 = 5'd8;
        #1;
        compared++;
        if (obs !== EXP_LU) begin
            mismatched++;
            $display("[TB] FAIL lu_over_imiss: got %b expected %b", obs, EXP_LU);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_halt();
        idle_inputs();
        memwb_halt = 1'b1;
        #1;
        compared++;
        if (obs !== EXP_NORMAL) begin
            mismatched++;
            $display("[TB] FAIL halt_entry_cycle: got %b expected %b", obs, EXP_NORMAL);
        end
        tick();
        memwb_halt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            compared++;
            if (obs !== EXP_DRAIN) begin
                mismatched++;
                $display("[TB] FAIL drain_cycle[%0d]: got %b expected %b", i, obs, EXP_DRAIN);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            ihit = i[0]; exmem_redirect = i[1]; exmem_dREN = 1'b1;
            #1;
            compared++;
            if (obs !== EXP_HALTED) begin
                mismatched++;
                $display("[TB] FAIL halted[%0d]: got %b expected %b", i, obs, EXP_HALTED);
            end
            tick();
        end
        idle_inputs();
        nRST = 1'b0;
        #1;
        compared++;
        if (obs !== EXP_NORMAL) begin
            mismatched++;
            $display("[TB] FAIL halted_async_reset: got %b expected %b", obs, EXP_NORMAL);
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_halt_priority();
        idle_inputs();
        memwb_halt = 1'b1; exmem_dREN = 1'b1; dhit = 1'b0;
        #1;
        compared++;
        if (obs !== EXP_MSTALL) begin
            mismatched++;
            $display("[TB] FAIL halt_mstall_cycle: got %b expected %b", obs, EXP_MSTALL);
        end
        tick();
        idle_inputs();
        #1;
        compared++;
        if (obs !== EXP_DRAIN) begin
            mismatched++;
            $display("[TB] FAIL halt_beats_mstall: got %b expected %b", obs, EXP_DRAIN);
        end
        pulse_reset();
        tick();
        exmem_dREN = 1'b1; dhit = 1'b0;
        tick();
        memwb_halt = 1'b1;
        tick();
        idle_inputs();
        #1;
        compared++;
        if (obs !== EXP_DRAIN) begin
            mismatched++;
            $display("[TB] FAIL halt_from_memwait: got %b expected %b", obs, EXP_DRAIN);
        end
        pulse_reset();
        tick();
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        memwb_halt = 1'b1;
        tick();
        memwb_halt = 1'b0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (obs !== EXP_NORMAL) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_drain[%0d]: got %b expected %b", i, obs, EXP_NORMAL);
            end
        end
    endtask

`ifdef HAZ_PERF_EN
    task automatic test_perf();
        idle_inputs();
        pulse_reset();
        compared++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL perf_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        ihit = 1'b0;
        repeat (4) tick();
        ihit = 1'b1; exmem_redirect = 1'b1;
        repeat (2) tick();
        idle_inputs();
        tick();
        compared++;
        if (stall_cnt !== 32'd4) begin
            mismatched++;
            $display("[TB] FAIL perf_stall: got %0d expected 4", stall_cnt);
        end
        compared++;
        if (flush_cnt !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL perf_flush: got %0d expected 2", flush_cnt);
        end
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        dut.flush_cnt_q = 32'hFFFF_FFFF;
        ihit = 1'b0;
        tick();
        ihit = 1'b1; exmem_redirect = 1'b1;
        tick();
        idle_inputs();
        compared++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL perf_wrap: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_dcache_miss();
        test_redirect();
        test_icache_miss();
        test_halt();
        test_halt_priority();
        test_reset_mid_drain();
`ifdef HAZ_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
